// File: rtl/gost_pkg.sv
// ============================================================================
// Module      : gost_pkg
// Description : Shared constants, S-box table and helpers for the GOST core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gost_pkg;

  localparam int c_half_w      = 32;
  localparam int c_block_w     = 64;
  localparam int c_key_w       = 256;
  localparam int c_rounds_full = 32;
  localparam int c_rounds_imit = 16;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  // Row i is S-box i; nibble x of a row holds S_i(x).
  localparam logic [7:0][63:0] c_sbox = {
    64'hC8B6E3294A750DF1,
    64'hC2867EA095F314BD,
    64'hEFC95863D1270AB4,
    64'h2B30E9A48DF517C6,
    64'h352BC64EF9801AD7,
    64'hB9067CFE243AD185,
    64'h95701832AFD6C4BE,
    64'h35F7C1B6E08D29A4
  };

  function automatic logic [c_half_w-1:0] sbox_sub(input logic [c_half_w-1:0] x);
    logic [c_half_w-1:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y[4*i +: 4] = c_sbox[i][{x[4*i +: 4], 2'b00} +: 4];
    end
    return y;
  endfunction

  // Zero-based subkey index; both directions walk K1..K8 forward then backward,
  // differing only in where the backward walk starts.
  function automatic logic [2:0] subkey_idx(input logic [4:0] rnd, input logic decrypt);
    logic [4:0] split;
    split = decrypt ? 5'd8 : 5'd24;
    return (rnd < split) ? rnd[2:0] : (3'd7 - rnd[2:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gost_round_comb.sv
// ============================================================================
// Module      : gost_round_comb
// Description : One combinational GOST 28147-89 Feistel round.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gost_round_comb
  import gost_pkg::*;
(
  input  logic [c_half_w-1:0] a,
  input  logic [c_half_w-1:0] b,
  input  logic [c_half_w-1:0] k,
  output logic [c_half_w-1:0] a_nxt,
  output logic [c_half_w-1:0] b_nxt
);

  logic [c_half_w-1:0] w_sum;
  logic [c_half_w-1:0] w_sub;

  assign w_sum = a + k;
  assign w_sub = sbox_sub(w_sum);
  assign a_nxt = b ^ {w_sub[20:0], w_sub[31:21]};
  assign b_nxt = a;

endmodule

`default_nettype wire

// File: rtl/gost_iter_core.sv
// ============================================================================
// Module      : gost_iter_core
// Description : Iterative GOST 28147-89 core, ROUNDS_PER_CYCLE rounds/clock.
//               Optional MAC (imitovstavka) mode enabled by macro GOST_IMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gost_iter_core
  import gost_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [c_block_w-1:0] in_data,
  input  logic [c_key_w-1:0]   in_key,
  input  logic                 in_decrypt,
`ifdef GOST_IMIT_EN
  input  logic                 in_imit,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [c_block_w-1:0] out_data,
  output logic                 busy
);

  localparam logic [5:0] c_step = 6'(ROUNDS_PER_CYCLE);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rounds
    $error("gost_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [c_half_w-1:0]  r_a;
  logic [c_half_w-1:0]  r_b;
  logic [c_key_w-1:0]   r_key;
  logic                 r_dec;
  logic [5:0]           r_cnt;
  logic [c_block_w-1:0] r_out;
  logic [5:0]           w_limit;
  logic                 w_accept;
  logic                 w_last;
  logic [c_half_w-1:0]  w_a_fin;
  logic [c_half_w-1:0]  w_b_fin;
  logic [c_block_w-1:0] w_out;

  assign w_accept = in_valid && (r_state == c_st_idle);
  assign w_last   = (r_state == c_st_run) && ((r_cnt + c_step) == w_limit);

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [c_half_w-1:0] w_a_i, w_b_i, w_a_o, w_b_o, w_k;
    logic [4:0]          w_rnd;
    logic [2:0]          w_kidx;

    if (j == 0) begin : g_head
      assign w_a_i = r_a;
      assign w_b_i = r_b;
    end else begin : g_link
      assign w_a_i = g_round[j-1].w_a_o;
      assign w_b_i = g_round[j-1].w_b_o;
    end

    assign w_rnd  = r_cnt[4:0] + 5'(j);
    assign w_kidx = subkey_idx(w_rnd, r_dec);
    assign w_k    = r_key[{w_kidx, 5'd0} +: c_half_w];

    gost_round_comb u_round (
      .a     (w_a_i),
      .b     (w_b_i),
      .k     (w_k),
      .a_nxt (w_a_o),
      .b_nxt (w_b_o)
    );
  end

  assign w_a_fin = g_round[ROUNDS_PER_CYCLE-1].w_a_o;
  assign w_b_fin = g_round[ROUNDS_PER_CYCLE-1].w_b_o;

`ifdef GOST_IMIT_EN
  logic r_imit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imit <= 1'b0;
    end else if (w_accept) begin
      r_imit <= in_imit;
    end
  end

  // MAC results keep the final swap.
  assign w_limit = r_imit ? 6'(c_rounds_imit) : 6'(c_rounds_full);
  assign w_out   = r_imit ? {w_b_fin, w_a_fin} : {w_a_fin, w_b_fin};
`else
  assign w_limit = 6'(c_rounds_full);
  assign w_out   = {w_a_fin, w_b_fin};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: if (in_valid)  w_next = c_st_run;
      c_st_run:  if (w_last)    w_next = c_st_done;
      c_st_done: if (out_ready) w_next = c_st_idle;
      default:                  w_next = c_st_idle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_st_idle);
    out_valid = (r_state == c_st_done);
    busy      = (r_state != c_st_idle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_key <= '0;
      r_dec <= 1'b0;
      r_cnt <= '0;
      r_out <= '0;
    end else if (w_accept) begin
      r_a   <= in_data[31:0];
      r_b   <= in_data[63:32];
      r_key <= in_key;
`ifdef GOST_IMIT_EN
      r_dec <= in_decrypt & ~in_imit;
`else
      r_dec <= in_decrypt;
`endif
      r_cnt <= '0;
    end else if (r_state == c_st_run) begin
      r_a   <= w_a_fin;
      r_b   <= w_b_fin;
      r_cnt <= r_cnt + c_step;
      if (w_last) begin
        r_out <= w_out;
      end
    end
  end

  assign out_data = r_out;

endmodule

`default_nettype wire

// File: tb/tb_gost_iter_core.sv
// ============================================================================
// Module      : tb_gost_iter_core
// Description : Directed bench for gost_iter_core with R=1,2,4,8 side by side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gost_iter_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [63:0]  in_data = '0;
  logic [255:0] in_key = '0;
  logic         in_decrypt = 1'b0;
  logic         in_imit = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   ir, ov, bs;
  logic [63:0]  od [4];

  int n_cmp = 0;
  int n_bad = 0;
  int lat [4];
  logic [63:0] res [4];
  int rr [4] = '{1, 2, 4, 8};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    gost_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (ir[g]),
      .in_data    (in_data),
      .in_key     (in_key),
      .in_decrypt (in_decrypt),
`ifdef GOST_IMIT_EN
      .in_imit    (in_imit),
`endif
      .out_valid  (ov[g]),
      .out_ready  (out_ready),
      .out_data   (od[g]),
      .busy       (bs[g])
    );
  end

  // Test-parameter S-boxes, nibble x of row i = S_i(x).
  logic [63:0] sbt [8] = '{
    64'h35F7C1B6E08D29A4, 64'h95701832AFD6C4BE, 64'hB9067CFE243AD185,
    64'h352BC64EF9801AD7, 64'h2B30E9A48DF517C6, 64'hEFC95863D1270AB4,
    64'hC2867EA095F314BD, 64'hC8B6E3294A750DF1
  };

  function automatic logic [63:0] model(input logic [63:0] d, input logic [255:0] k,
                                        input bit dec, input int nr, input bit imit);
    logic [31:0] n1, n2, t, s, tmp;
    int ki;
    n1 = d[31:0];
    n2 = d[63:32];
    for (int r = 0; r < nr; r++) begin
      if (!dec) ki = (r < 24) ? (r % 8) : (31 - r);
      else      ki = (r < 8) ? r : (7 - (r % 8));
      t = n1 + k[ki*32 +: 32];
      s = '0;
      for (int i = 0; i < 8; i++) s[4*i +: 4] = sbt[i][4*int'(t[4*i +: 4]) +: 4];
      s   = (s << 11) | (s >> 21);
      tmp = n2 ^ s;
      n2  = n1;
      n1  = tmp;
    end
    return imit ? {n2, n1} : {n1, n2};
  endfunction

  task automatic scramble();
    in_data    = {$urandom, $urandom};
    in_key     = {8{$urandom}};
    in_decrypt = $urandom_range(0, 1);
    in_imit    = $urandom_range(0, 1);
  endtask

  // Issue one request to all four cores, record latency and result of each.
  task automatic run_op(input logic [63:0] d, input logic [255:0] k, input bit dec, input bit imit);
    bit seen [4];
    int cyc;
    n_cmp++;
    if (ir !== 4'hF) begin
      n_bad++;
      $display("FAIL ready_before_op: got %b want 1111", ir);
    end
    in_data = d; in_key = k; in_decrypt = dec; in_imit = imit; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin seen[i] = 0; lat[i] = 0; res[i] = 'x; end
    cyc = 0;
    while (!(seen[0] && seen[1] && seen[2] && seen[3]) && cyc < 100) begin
      scramble();
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (!seen[i] && ov[i]) begin seen[i] = 1; lat[i] = cyc + 1; res[i] = od[i]; end
      end
    end
    if (cyc >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL op_timeout: out_valid=%b after %0d clocks, want 1111", ov, cyc);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_all(input string name, input logic [63:0] exp, input int nr);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (res[i] !== exp) begin
        n_bad++;
        $display("FAIL %s_data_r%0d: got %h want %h", name, rr[i], res[i], exp);
      end
      n_cmp++;
      if (lat[i] !== nr / rr[i] + 1) begin
        n_bad++;
        $display("FAIL %s_latency_r%0d: got %0d want %0d", name, rr[i], lat[i], nr / rr[i] + 1);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({ir[i], ov[i], bs[i]} !== 3'b100 || od[i] !== 64'h0) begin
        n_bad++;
        $display("FAIL reset_r%0d: ready/valid/busy=%b data=%h want 100 data=0",
                 rr[i], {ir[i], ov[i], bs[i]}, od[i]);
      end
    end
  endtask

  task automatic test_zero_vector();
    run_op('0, '0, 1'b0, 1'b0);
    check_all("zero", model('0, '0, 1'b0, 32, 1'b0), 32);
  endtask

  task automatic test_roundtrip();
    logic [255:0] k;
    logic [63:0]  ct;
    k = {2{64'h0123456789ABCDEF, 64'hFEDCBA9876543210}};
    run_op(64'hFEDCBA9876543210, k, 1'b0, 1'b0);
    ct = res[0];
    check_all("rt_enc", model(64'hFEDCBA9876543210, k, 1'b0, 32, 1'b0), 32);
    run_op(ct, k, 1'b1, 1'b0);
    check_all("rt_dec", 64'hFEDCBA9876543210, 32);
  endtask

  task automatic test_param_sweep();
    logic [63:0]  d;
    logic [255:0] k;
    for (int n = 0; n < 256; n++) begin
      d = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_op(d, k, n[0], 1'b0);
      check_all("sweep", model(d, k, n[0], 32, 1'b0), 32);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0]  d, hold;
    logic [255:0] k;
    int cyc;
    d = 64'h0011223344556677;
    k = {8{32'hA5A5_5A5A}};
    in_data = d; in_key = k; in_decrypt = 1'b0; in_imit = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!ov[0] && cyc < 100) begin @(posedge clk); #1; cyc++; end
    hold = od[0];
    n_cmp++;
    if (hold !== model(d, k, 1'b0, 32, 1'b0)) begin
      n_bad++;
      $display("FAIL bp_data: got %h want %h", hold, model(d, k, 1'b0, 32, 1'b0));
    end
    for (int c = 0; c < 10; c++) begin
      in_data = {$urandom, $urandom};
      in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (od[0] !== hold || {ov[0], ir[0], bs[0]} !== 3'b101) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: data=%h valid/ready/busy=%b want %h 101",
                 c, od[0], {ov[0], ir[0], bs[0]}, hold);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if ({ov[0], ir[0], bs[0]} !== 3'b010 || od[0] !== hold) begin
      n_bad++;
      $display("FAIL bp_release: valid/ready/busy=%b data=%h want 010 %h",
               {ov[0], ir[0], bs[0]}, od[0], hold);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0]  d;
    logic [255:0] k;
    bit           seen;
    d = 64'hDEADBEEF_CAFEF00D;
    k = {8{32'h1357_9BDF}};
    in_data = d; in_key = k; in_decrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    rst = 1'b1;
    #2;
    n_cmp++;
    if (ov !== 4'h0 || bs !== 4'h0) begin
      n_bad++;
      $display("FAIL midrun_async: valid=%b busy=%b want 0000 0000", ov, bs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ov !== 4'h0) seen = 1; end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL midrun_no_valid: got out_valid after reset, want none");
    end
    run_op(d, k, 1'b0, 1'b0);
    check_all("after_rst", model(d, k, 1'b0, 32, 1'b0), 32);
  endtask

`ifdef GOST_IMIT_EN
  task automatic test_imit();
    logic [63:0]  d;
    logic [255:0] k;
    d = 64'h0123456789ABCDEF;
    k = {2{64'h0123456789ABCDEF, 64'hFEDCBA9876543210}};
    run_op(d, k, 1'b1, 1'b1);
    check_all("imit", model(d, k, 1'b0, 16, 1'b1), 16);
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_zero_vector();
    test_roundtrip();
    test_backpressure();
    test_reset_mid_run();
`ifdef GOST_IMIT_EN
    test_imit();
`endif
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
